sync_fifo_flex: RTL and testbench

// - Single-clock parametrised FIFO: generic width/depth, occupancy count, programmable almost-full/almost-empty flags,

---
 rtl/sync_fifo_flex.sv | 155 +++++++++++++++
 tb/tb_sync_fifo_flex.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// Single-clock parametrised FIFO with occupancy count, almost flags, sticky error flags and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; default is 1-cycle registered read latency.
module sync_fifo_flex #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     winc,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rinc,
    output logic [WIDTH-1:0]         rdata,
    output logic                     wfull,
    output logic                     rempty,
    output logic                     walmost_full,
    output logic                     ralmost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      waddr;
    logic [AW:0]      raddr;
    logic             wenc;
    logic             renc;

    assign wenc = winc & ~wfull;
    assign renc = rinc & ~rempty;

    assign walmost_full  = (count >= AFULL_C);
    assign ralmost_empty = (count <= AEMPTY_C);

    // Storage array is deliberately left unreset; only written entries are ever read.
    always_ff @(posedge clk) begin
        if (wenc && !flush) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({wenc, renc})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                overflow <= 1'b1;
            end
            if (rinc && rempty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The output register holds the head word, so the array drains into it
    // whenever it is empty or being popped; count covers both.
    logic ovalid;
    logic ram_empty;
    logic load;

    assign ram_empty = (waddr == raddr);
    assign load      = ~ram_empty & (~ovalid | renc);
    assign wfull     = (count == DEPTH_C);
    assign rempty    = ~ovalid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            waddr <= '0;
            raddr <= '0;
        end else if (flush) begin
            waddr <= '0;
            raddr <= '0;
        end else begin
            if (wenc) begin
                waddr <= waddr + PTR_ONE;
            end
            if (load) begin
                raddr <= raddr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata  <= '0;
            ovalid <= 1'b0;
        end else if (flush) begin
            ovalid <= 1'b0;
        end else if (load) begin
            rdata  <= mem[raddr[AW-1:0]];
            ovalid <= 1'b1;
        end else if (renc) begin
            ovalid <= 1'b0;
        end
    end
`else
    // The extra wrap bit distinguishes full from empty when the indices match.
    assign wfull  = (waddr[AW] != raddr[AW]) && (waddr[AW-1:0] == raddr[AW-1:0]);
    assign rempty = (waddr == raddr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            waddr <= '0;
            raddr <= '0;
        end else if (flush) begin
            waddr <= '0;
            raddr <= '0;
        end else begin
            if (wenc) begin
                waddr <= waddr + PTR_ONE;
            end
            if (renc) begin
                raddr <= raddr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (renc && !flush) begin
            rdata <= mem[raddr[AW-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex: vector table plus a queue scoreboard.
// Under SYNC_FIFO_FWFT_EN a reduced fall-through sequence is run instead.
module tb_sync_fifo_flex;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rstn;
    logic             flush;
    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             rinc;
    logic [WIDTH-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             walmost_full;
    logic             ralmost_empty;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    sync_fifo_flex #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(6), .AEMPTY_TH(1)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .winc(winc), .wdata(wdata),
        .rinc(rinc), .rdata(rdata), .wfull(wfull), .rempty(rempty),
        .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       f;
        int         cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t       vecs [19];
    logic [7:0] q [$];
    logic [7:0] mrdata;
    logic       mover;
    logic       munder;
    int         passCount;
    int         checkCount;

    task automatic checkOutput(input string name, input int got, input int exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic driveCycle(input logic w, input logic [7:0] d, input logic r, input logic f);
        winc  = w;
        wdata = d;
        rinc  = r;
        flush = f;
        @(posedge clk);
        #1;
        winc  = 1'b0;
        rinc  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic checkModel();
        checkOutput("count",         int'(count),         q.size());
        checkOutput("wfull",         int'(wfull),         int'(q.size() == DEPTH));
        checkOutput("rempty",        int'(rempty),        int'(q.size() == 0));
        checkOutput("walmost_full",  int'(walmost_full),  int'(q.size() >= 6));
        checkOutput("ralmost_empty", int'(ralmost_empty), int'(q.size() <= 1));
        checkOutput("overflow",      int'(overflow),      int'(mover));
        checkOutput("underflow",     int'(underflow),     int'(munder));
        checkOutput("rdata",         int'(rdata),         int'(mrdata));
    endtask

    // One clock of stimulus, then the scoreboard predicts and compares every output.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic f);
        int pre;
        pre = q.size();
        driveCycle(w, d, r, f);
        if (f) begin
            q.delete();
            mover  = 1'b0;
            munder = 1'b0;
        end else begin
            if (w && pre == DEPTH) mover = 1'b1;
            if (r && pre == 0) munder = 1'b1;
            if (r && pre > 0) mrdata = q.pop_front();
            if (w && pre < DEPTH) q.push_back(d);
        end
        checkModel();
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        mrdata     = 8'h00;
        mover      = 1'b0;
        munder     = 1'b0;
        rstn       = 1'b0;
        flush      = 1'b0;
        winc       = 1'b0;
        rinc       = 1'b0;
        wdata      = 8'h00;

        vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h06, 1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h07, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h08, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        checkModel();
        rstn = 1'b1;
        @(posedge clk);
        #1;

`ifdef SYNC_FIFO_FWFT_EN
        for (int i = 1; i <= 8; i++) driveCycle(1'b1, 8'(i), 1'b0, 1'b0);
        driveCycle(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("fwft rempty", int'(rempty), 0);
        checkOutput("fwft rdata",  int'(rdata), 8'h01);
        checkOutput("fwft count",  int'(count), 8);
        checkOutput("fwft wfull",  int'(wfull), 1);
        for (int i = 1; i <= 8; i++) begin
            checkOutput("fwft head", int'(rdata), i);
            driveCycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("fwft rempty end", int'(rempty), 1);
        checkOutput("fwft count end",  int'(count), 0);
        checkOutput("fwft underflow",  int'(underflow), 0);
`else
        // Fill, overflow, drain, underflow and flush against fixed expectations.
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].f);
            checkOutput($sformatf("row%0d count", i),  int'(count),         vecs[i].cnt);
            checkOutput($sformatf("row%0d wfull", i),  int'(wfull),         int'(vecs[i].full));
            checkOutput($sformatf("row%0d rempty", i), int'(rempty),        int'(vecs[i].empty));
            checkOutput($sformatf("row%0d afull", i),  int'(walmost_full),  int'(vecs[i].af));
            checkOutput($sformatf("row%0d aempty", i), int'(ralmost_empty), int'(vecs[i].ae));
            checkOutput($sformatf("row%0d ovf", i),    int'(overflow),      int'(vecs[i].ov));
            checkOutput($sformatf("row%0d unf", i),    int'(underflow),     int'(vecs[i].un));
        end
        checkOutput("drained rdata", int'(rdata), 8'h08);

        // Steady count of four while pointers wrap several times.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h14 + i), 1'b1, 1'b0);
        checkOutput("wrap count", int'(count), 4);

        // Simultaneous access at full, then at empty.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hBB, 1'b1, 1'b0);
        checkOutput("full rw count", int'(count), 7);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hCC, 1'b1, 1'b0);
        checkOutput("empty rw count", int'(count), 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("empty rw data", int'(rdata), 8'hCC);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        q.delete();
        mrdata = 8'h00;
        mover  = 1'b0;
        munder = 1'b0;
        checkModel();
        #2;
        rstn = 1'b1;
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post reset data", int'(rdata), 8'h55);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
